signed_mult_seq_ctrl: RTL

Sequential controller for the calculator's signed multiply path. It accepts two WIDTH-bit two's-complement operands and converts negative operands to magnitude using invert-plus-carry-in, the same scheme as the one's-complement XOR adder. It then runs WIDTH shift-add iterations on the magnitudes and conditionally negates the 2*WIDTH-bit result. It sits between the calculator's operation decoder and the result register, with a start/busy/done handshake.

---
 rtl/signed_mult_seq_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/signed_mult_seq_ctrl.sv
// Sequential signed multiplier controller for the calculator multiply path.
// Operands are converted to magnitudes (invert plus carry-in), multiplied by
// WIDTH shift-add iterations, and the 2*WIDTH-bit result is negated when the
// operand signs differ. Latency from start acceptance to done is WIDTH+3 edges.
//
// Ports:
//   clk     - system clock, rising-edge active
//   rst     - asynchronous active-high reset
//   start   - operation request, sampled only in IDLE
//   a, b    - WIDTH-bit two's-complement multiplicand / multiplier
//   busy    - high from the cycle after acceptance through the DONE cycle
//   done    - single-cycle pulse, product valid
//   product - 2*WIDTH-bit signed result, held until the next FIX edge
module signed_mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2*WIDTH-1:0] PONE = (2*WIDTH)'(1);

  typedef enum logic [2:0] {IDLE, ABS, MULT, FIX, DONE} state_t;

  state_t             state, next_state;
  logic               sign;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   acc_hi;
  // Holds the multiplier magnitude; low product bits shift in from the top.
  logic [WIDTH-1:0]   mult;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc;
  logic               last_iter;

  always_comb begin
    sum       = {1'b0, acc_hi} + (mult[0] ? {1'b0, mag_a} : '0);
    acc       = {acc_hi, mult};
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ABS;
      ABS:     next_state = MULT;
      MULT:    if (last_iter) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      sign    <= 1'b0;
      mag_a   <= '0;
      acc_hi  <= '0;
      mult    <= '0;
      cnt     <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      case (state)
        IDLE: if (start) begin
          mag_a <= a;
          mult  <= b;
          sign  <= a[WIDTH-1] ^ b[WIDTH-1];
        end
        ABS: begin
          // XOR with all-ones plus carry-in of the sign bit; -2^(W-1) maps to
          // 2^(W-1), which still fits the unsigned magnitude register.
          mag_a  <= (mag_a ^ {WIDTH{mag_a[WIDTH-1]}}) + WIDTH'(mag_a[WIDTH-1]);
          mult   <= (mult ^ {WIDTH{mult[WIDTH-1]}}) + WIDTH'(mult[WIDTH-1]);
          acc_hi <= '0;
          cnt    <= '0;
        end
        MULT: begin
          // Shift {carry, acc_hi, mult} right by one after the conditional add.
          acc_hi <= sum[WIDTH:1];
          mult   <= {sum[0], mult[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
        end
        FIX: product <= sign ? (~acc + PONE) : acc;
        default: ;
      endcase
    end
  end

endmodule
